// File: rtl/psychic5_ioctl_loader.sv
// psychic5_ioctl_loader: pairs ioctl ROM bytes into 16-bit words, buffers them and writes them to SDRAM
module psychic5_ioctl_loader #(
  parameter logic [15:0] ROM_INDEX  = 16'h0000,
  parameter logic [23:0] BASE_WADDR = 24'h000000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        i_EMU_MCLK,
  input  logic        i_EMU_INITRST,
  input  logic [15:0] i_IOCTL_INDEX,
  input  logic        i_IOCTL_DOWNLOAD,
  input  logic [26:0] i_IOCTL_ADDR,
  input  logic [7:0]  i_IOCTL_DATA,
  input  logic        i_IOCTL_WR,
  output logic        o_IOCTL_WAIT,
  output logic        o_SDRAM_WR_REQ,
  output logic [23:0] o_SDRAM_WR_ADDR,
  output logic [15:0] o_SDRAM_WR_DATA,
  output logic [1:0]  o_SDRAM_WR_BE,
  input  logic        i_SDRAM_WR_ACK,
  output logic        o_CORE_RST,
  output logic        o_DONE,
  output logic        o_OVERFLOW
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0] HIGH = (AW+1)'(FIFO_DEPTH - 1);
  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DONE} state_t;
  state_t state_q, state_d;
  logic [41:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [AW:0] cnt_q, cnt_d;
  logic pend_v_q, pend_v_d, dbl_v_q, dbl_v_d;
  logic [7:0] pend_b_q, pend_b_d;
  logic [23:0] pend_w_q, pend_w_d, w;
  logic [41:0] dbl_e_q, dbl_e_d, push_e, pend_e, odd_e, out_q, out_d;
  logic acc, push, pop, req_q, req_d, wait_q, wait_d, crst_q, crst_d, ovf_q, ovf_d;
  // Byte pairing: decide what (if anything) enters the FIFO this cycle; a queued second push wins over new bytes
  always_comb begin
    w = BASE_WADDR + i_IOCTL_ADDR[24:1];
    acc = state_q == LOAD && i_IOCTL_WR && i_IOCTL_ADDR[26:25] == 2'b00 && !dbl_v_q;
    pend_e = {pend_w_q, 8'h00, pend_b_q, 2'b01};
    odd_e = {w, i_IOCTL_DATA, 8'h00, 2'b10};
    push = 1'b0;
    push_e = pend_e;
    pend_v_d = pend_v_q;
    pend_b_d = pend_b_q;
    pend_w_d = pend_w_q;
    dbl_v_d = 1'b0;
    dbl_e_d = dbl_e_q;
    if (dbl_v_q) begin
      push = 1'b1;
      push_e = dbl_e_q;
    end else if (acc && !i_IOCTL_ADDR[0]) begin
      push = pend_v_q;
      pend_v_d = 1'b1;
      pend_b_d = i_IOCTL_DATA;
      pend_w_d = w;
    end else if (acc && pend_v_q && pend_w_q == w) begin
      push = 1'b1;
      push_e = {w, i_IOCTL_DATA, pend_b_q, 2'b11};
      pend_v_d = 1'b0;
    end else if (acc) begin
      push = 1'b1;
      push_e = pend_v_q ? pend_e : odd_e;
      dbl_v_d = pend_v_q;
      dbl_e_d = odd_e;
      pend_v_d = 1'b0;
    end else if (state_q == FLUSH && pend_v_q && cnt_q != FULL) begin
      push = 1'b1;
      pend_v_d = 1'b0;
    end
  end
  // FIFO bookkeeping and SDRAM head register; REQ follows the count before this cycle's push
  always_comb begin
    pop = req_q && i_SDRAM_WR_ACK;
    wp_d = wp_q + AW'(push);
    rp_d = rp_q + AW'(pop);
    cnt_d = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    req_d = cnt_q != (AW+1)'(pop);
    out_d = req_d ? mem_q[rp_d] : out_q;
    wait_d = cnt_d >= HIGH || dbl_v_d;
    ovf_d = ovf_q || (state_q == LOAD && i_IOCTL_WR && i_IOCTL_ADDR[26:25] != 2'b00);
    crst_d = state_q == DONE ? 1'b0 : state_q == LOAD ? 1'b1 : crst_q;
  end
  // Download sequencing: load, drain everything to SDRAM, then pulse done
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (i_IOCTL_DOWNLOAD && i_IOCTL_INDEX == ROM_INDEX) state_d = LOAD;
      LOAD:  if (!i_IOCTL_DOWNLOAD) state_d = FLUSH;
      FLUSH: if (cnt_q == '0 && !req_q && !pend_v_q && !dbl_v_q) state_d = DONE;
      DONE:  state_d = IDLE;
    endcase
  end
  // FIFO storage needs no reset; occupancy is tracked by the pointers and count
  always_ff @(posedge i_EMU_MCLK) begin
    if (push) mem_q[wp_q] <= push_e;
  end
  // State registers
  always_ff @(posedge i_EMU_MCLK) begin
    if (i_EMU_INITRST) begin
      state_q <= IDLE;
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
      pend_v_q <= 1'b0;
      pend_b_q <= '0;
      pend_w_q <= '0;
      dbl_v_q <= 1'b0;
      dbl_e_q <= '0;
      out_q <= '0;
      req_q <= 1'b0;
      wait_q <= 1'b0;
      crst_q <= 1'b1;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wp_q <= wp_d;
      rp_q <= rp_d;
      cnt_q <= cnt_d;
      pend_v_q <= pend_v_d;
      pend_b_q <= pend_b_d;
      pend_w_q <= pend_w_d;
      dbl_v_q <= dbl_v_d;
      dbl_e_q <= dbl_e_d;
      out_q <= out_d;
      req_q <= req_d;
      wait_q <= wait_d;
      crst_q <= crst_d;
      ovf_q <= ovf_d;
    end
  end
  assign o_IOCTL_WAIT = wait_q;
  assign o_SDRAM_WR_REQ = req_q;
  assign o_SDRAM_WR_ADDR = out_q[41:18];
  assign o_SDRAM_WR_DATA = out_q[17:2];
  assign o_SDRAM_WR_BE = out_q[1:0];
  assign o_CORE_RST = crst_q || state_q != IDLE;
  assign o_DONE = state_q == DONE;
  assign o_OVERFLOW = ovf_q;
endmodule

// File: tb/tb_psychic5_ioctl_loader.sv
// tb_psychic5_ioctl_loader: vector table plus hand sequences, SDRAM writes checked against a queue
`timescale 1ns/1ps
module tb_psychic5_ioctl_loader;
  localparam logic [23:0] BASE = 24'h100000;
  logic clk = 0, rst = 1, dl = 0, wr = 0, ack = 1;
  logic [15:0] idx = 0;
  logic [26:0] addr = 0;
  logic [7:0] data = 0;
  logic o_IOCTL_WAIT, o_SDRAM_WR_REQ, o_CORE_RST, o_DONE, o_OVERFLOW;
  logic [23:0] o_SDRAM_WR_ADDR;
  logic [15:0] o_SDRAM_WR_DATA;
  logic [1:0] o_SDRAM_WR_BE;
  typedef struct {
    logic [26:0] a;
    logic [7:0] d;
    int n;
    logic [41:0] w0;
    logic [41:0] w1;
    bit first;
    bit last;
  } vec_t;
  vec_t tv [13];
  logic [41:0] q [$];
  logic [41:0] held = 0;
  logic req_p = 0, ack_p = 0, ovf_exp = 0;
  int n_chk = 0, n_pass = 0, done_cnt = 0, n_wr = 0, sent = 0;

  psychic5_ioctl_loader #(.ROM_INDEX(16'h0000), .BASE_WADDR(BASE), .FIFO_DEPTH(4)) dut (
    .i_EMU_MCLK(clk), .i_EMU_INITRST(rst), .i_IOCTL_INDEX(idx), .i_IOCTL_DOWNLOAD(dl),
    .i_IOCTL_ADDR(addr), .i_IOCTL_DATA(data), .i_IOCTL_WR(wr), .o_IOCTL_WAIT(o_IOCTL_WAIT),
    .o_SDRAM_WR_REQ(o_SDRAM_WR_REQ), .o_SDRAM_WR_ADDR(o_SDRAM_WR_ADDR), .o_SDRAM_WR_DATA(o_SDRAM_WR_DATA),
    .o_SDRAM_WR_BE(o_SDRAM_WR_BE), .i_SDRAM_WR_ACK(ack), .o_CORE_RST(o_CORE_RST), .o_DONE(o_DONE),
    .o_OVERFLOW(o_OVERFLOW));

  always #5 clk = ~clk;

  function automatic logic [41:0] ent(int w, logic [15:0] d, logic [1:0] be);
    return {BASE + 24'(w), d, be};
  endfunction

  function automatic vec_t v(logic [26:0] a, logic [7:0] d, int n, logic [41:0] w0, logic [41:0] w1, bit f, bit l);
    vec_t r;
    r.a = a; r.d = d; r.n = n; r.w0 = w0; r.w1 = w1; r.first = f; r.last = l;
    return r;
  endfunction

  function automatic logic [7:0] bp(int i);
    return 8'(8'h40 + i);
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, required %h", nm, act, exp);
  endtask

  // Scoreboard: every accepted write must match the oldest expected write; requests must hold until acked
  always @(negedge clk) begin
    if (rst) begin
      req_p = 0;
      ack_p = 0;
    end else begin
      if (o_DONE) done_cnt++;
      if (req_p && !ack_p)
        chk("hold", {21'b0, o_SDRAM_WR_REQ, o_SDRAM_WR_ADDR, o_SDRAM_WR_DATA, o_SDRAM_WR_BE}, {21'b0, 1'b1, held});
      if (o_SDRAM_WR_REQ && ack) begin
        n_wr++;
        if (q.size() == 0) begin
          n_chk++;
          $display("FAIL write: got %h/%h/%h, required no write", o_SDRAM_WR_ADDR, o_SDRAM_WR_DATA, o_SDRAM_WR_BE);
        end else chk("write", {22'b0, o_SDRAM_WR_ADDR, o_SDRAM_WR_DATA, o_SDRAM_WR_BE}, {22'b0, q.pop_front()});
      end
      req_p = o_SDRAM_WR_REQ;
      ack_p = ack;
      held = {o_SDRAM_WR_ADDR, o_SDRAM_WR_DATA, o_SDRAM_WR_BE};
    end
  end

  task automatic send_byte(logic [26:0] a, logic [7:0] d);
    for (int k = 0; o_IOCTL_WAIT && k < 200; k++) begin
      @(posedge clk);
      #1;
    end
    if (o_IOCTL_WAIT) begin
      n_chk++;
      $display("FAIL wait_timeout: got wait=1 after 200 cycles, required 0");
    end
    addr = a;
    data = d;
    wr = 1;
    @(posedge clk);
    #1;
    wr = 0;
  endtask

  task automatic finish_dl();
    int d0;
    d0 = done_cnt;
    dl = 0;
    for (int k = 0; done_cnt == d0 && k < 500; k++) @(negedge clk);
    repeat (3) @(negedge clk);
    chk("done_pulses", 64'(done_cnt), 64'(d0 + 1));
    chk("queue_drained", 64'(q.size()), 64'(0));
    chk("core_rst_released", 64'(o_CORE_RST), 64'(0));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1);
  end

  initial begin
    tv[0]  = v(27'd0,  8'h11, 0, '0, '0, 1, 0);
    tv[1]  = v(27'd1,  8'h22, 1, ent(0, 16'h2211, 2'b11), '0, 0, 0);
    tv[2]  = v(27'd2,  8'h33, 0, '0, '0, 0, 0);
    tv[3]  = v(27'd3,  8'h44, 1, ent(1, 16'h4433, 2'b11), '0, 0, 1);
    tv[4]  = v(27'd0,  8'hAA, 0, '0, '0, 1, 0);
    tv[5]  = v(27'd1,  8'hBB, 1, ent(0, 16'hBBAA, 2'b11), '0, 0, 0);
    tv[6]  = v(27'd2,  8'hCC, 1, ent(1, 16'h00CC, 2'b01), '0, 0, 1);
    tv[7]  = v(27'd5,  8'h5A, 1, ent(2, 16'h5A00, 2'b10), '0, 1, 0);
    tv[8]  = v(27'd8,  8'h8B, 1, ent(4, 16'h008B, 2'b01), '0, 0, 1);
    tv[9]  = v(27'd10, 8'h01, 1, ent(5, 16'h0001, 2'b01), '0, 1, 0);
    tv[10] = v(27'h2000000, 8'hEE, 0, '0, '0, 0, 0);
    tv[11] = v(27'd12, 8'h02, 0, '0, '0, 0, 0);
    tv[12] = v(27'd15, 8'h03, 2, ent(6, 16'h0002, 2'b01), ent(7, 16'h0300, 2'b10), 0, 1);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_wait", 64'(o_IOCTL_WAIT), 64'(0));
    chk("rst_req", 64'(o_SDRAM_WR_REQ), 64'(0));
    chk("rst_addr", 64'(o_SDRAM_WR_ADDR), 64'(0));
    chk("rst_data", 64'(o_SDRAM_WR_DATA), 64'(0));
    chk("rst_be", 64'(o_SDRAM_WR_BE), 64'(0));
    chk("rst_done", 64'(o_DONE), 64'(0));
    chk("rst_ovf", 64'(o_OVERFLOW), 64'(0));
    chk("rst_core", 64'(o_CORE_RST), 64'(1));
    rst = 0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 13; i++) begin
      if (tv[i].first) begin
        idx = 16'h0000;
        dl = 1;
        @(posedge clk);
        #1;
        chk("core_rst_load", 64'(o_CORE_RST), 64'(1));
      end
      if (tv[i].n > 0) q.push_back(tv[i].w0);
      if (tv[i].n > 1) q.push_back(tv[i].w1);
      if (tv[i].a[26:25] != 2'b00) ovf_exp = 1;
      send_byte(tv[i].a, tv[i].d);
      if (tv[i].last) begin
        finish_dl();
        chk("overflow", 64'(o_OVERFLOW), 64'(ovf_exp));
      end
    end
    // Foreign index: ignored completely
    begin
      int d0;
      d0 = done_cnt;
      idx = 16'h0001;
      dl = 1;
      send_byte(27'd0, 8'h99);
      send_byte(27'd1, 8'h98);
      repeat (3) begin
        @(posedge clk);
        #1;
        chk("foreign_req", 64'(o_SDRAM_WR_REQ), 64'(0));
        chk("foreign_wait", 64'(o_IOCTL_WAIT), 64'(0));
        chk("foreign_core_rst", 64'(o_CORE_RST), 64'(0));
      end
      dl = 0;
      repeat (4) @(posedge clk);
      #1;
      chk("foreign_no_done", 64'(done_cnt), 64'(d0));
      idx = 16'h0000;
    end
    // Empty download: done two cycles after the fall
    dl = 1;
    @(posedge clk);
    #1;
    dl = 0;
    @(posedge clk);
    #1;
    chk("done_lat1", 64'(o_DONE), 64'(0));
    @(posedge clk);
    #1;
    chk("done_lat2", 64'(o_DONE), 64'(1));
    @(posedge clk);
    #1;
    chk("done_lat3", 64'(o_DONE), 64'(0));
    chk("done_core_rst", 64'(o_CORE_RST), 64'(0));
    // REQ latency after second byte of a pair
    dl = 1;
    @(posedge clk);
    #1;
    ack = 0;
    q.push_back(ent(0, 16'hCDAB, 2'b11));
    send_byte(27'd0, 8'hAB);
    send_byte(27'd1, 8'hCD);
    chk("req_lat1", 64'(o_SDRAM_WR_REQ), 64'(0));
    @(posedge clk);
    #1;
    chk("req_lat2", 64'(o_SDRAM_WR_REQ), 64'(1));
    @(posedge clk);
    #1;
    ack = 1;
    finish_dl();
    // Back-pressure with ACK held low, then sustained drain
    dl = 1;
    @(posedge clk);
    #1;
    ack = 0;
    sent = 0;
    fork
      begin
        for (int i = 0; i < 16; i++) begin
          if (i % 2 == 1) q.push_back(ent(i / 2, {bp(i), bp(i - 1)}, 2'b11));
          send_byte(27'(i), bp(i));
          sent++;
        end
      end
      begin
        int w0;
        for (int k = 0; !o_IOCTL_WAIT && k < 300; k++) @(negedge clk);
        chk("wait_rise_bytes", 64'(sent), 64'(6));
        w0 = n_wr;
        repeat (5) @(negedge clk);
        chk("wait_held", 64'(o_IOCTL_WAIT), 64'(1));
        chk("no_write_without_ack", 64'(n_wr), 64'(w0));
        @(posedge clk);
        #1;
        ack = 1;
        w0 = n_wr;
        repeat (3) @(negedge clk);
        #1;
        chk("throughput", 64'(n_wr), 64'(w0 + 3));
      end
    join
    finish_dl();
    // Reset mid-download with words queued
    dl = 1;
    @(posedge clk);
    #1;
    ack = 0;
    for (int i = 0; i < 5; i++) send_byte(27'(i), 8'(8'h70 + i));
    repeat (2) @(posedge clk);
    #1;
    chk("req_before_rst", 64'(o_SDRAM_WR_REQ), 64'(1));
    rst = 1;
    dl = 0;
    @(posedge clk);
    #1;
    chk("rst_mid_req", 64'(o_SDRAM_WR_REQ), 64'(0));
    chk("rst_mid_core", 64'(o_CORE_RST), 64'(1));
    chk("rst_mid_ovf", 64'(o_OVERFLOW), 64'(0));
    rst = 0;
    ack = 1;
    repeat (6) @(posedge clk);
    #1;
    chk("rst_fifo_empty", 64'(o_SDRAM_WR_REQ), 64'(0));
    dl = 1;
    @(posedge clk);
    #1;
    q.push_back(ent(0, 16'h3412, 2'b11));
    send_byte(27'd0, 8'h12);
    send_byte(27'd1, 8'h34);
    finish_dl();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
